// File: rtl/msu_audio_feeder_if.sv
// Sample-memory read port and DAC ring-buffer write port of the MSU audio feeder.
// master = feeder side, slave = memory/buffer side.
interface msu_audio_feeder_if #(
  parameter int unsigned BUF_AW = 11,
  parameter int unsigned MEM_AW = 24
);
  logic              mem_rd_req;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_ack;
  logic [7:0]        mem_data;
  logic              pgm_we_n;
  logic [BUF_AW-1:0] pgm_address;
  logic [7:0]        pgm_data;

  modport master (
    output mem_rd_req, mem_addr, pgm_we_n, pgm_address, pgm_data,
    input  mem_rd_ack, mem_data
  );

  modport slave (
    input  mem_rd_req, mem_addr, pgm_we_n, pgm_address, pgm_data,
    output mem_rd_ack, mem_data
  );
endinterface

// File: rtl/msu_audio_feeder.sv
// Streams track bytes from sample memory into the DAC ring buffer and drives DAC play/reset.
// Looping at track end is built only when MSU_FEEDER_LOOP_EN is defined.
module msu_audio_feeder #(
  parameter int unsigned BUF_AW = 11,
  parameter int unsigned MEM_AW = 24
) (
  input  logic               clkin,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  input  logic [MEM_AW-1:0]  track_start,
  input  logic [MEM_AW-1:0]  track_end,
  input  logic [MEM_AW-1:0]  loop_point,
  input  logic               dac_status,
  msu_audio_feeder_if.master bus,
  output logic               dac_play,
  output logic               dac_reset,
  output logic               playing,
  output logic               underrun
);
  localparam int unsigned CntW = BUF_AW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(1) << BUF_AW;
  localparam logic [CntW-1:0] HalfCnt = CntW'(1) << (BUF_AW - 1);

  typedef enum logic [2:0] {
    StIdle, StPrime, StWait, StFill, StPad, StDrain1, StDrain2
  } state_e;

  state_e            r_state, w_state_d;
  logic              r_req, w_req_d;
  logic [MEM_AW-1:0] r_addr, w_addr_d;
  logic [MEM_AW-1:0] r_end, w_end_d;
  logic [7:0]        r_data, w_data_d;
  logic              r_pend, w_pend_d;
  logic              r_we_n, w_we_n_d;
  logic [BUF_AW-1:0] r_pgm_addr, w_pgm_addr_d;
  logic [7:0]        r_pgm_data, w_pgm_data_d;
  logic [BUF_AW-1:0] r_wptr, w_wptr_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic              r_prime, w_prime_d;
  logic              r_abort, w_abort_d;
  logic              r_play, w_play_d;
  logic              r_dac_reset, w_dac_reset_d;
  logic              r_playing, w_playing_d;
  logic              r_underrun, w_underrun_d;
  logic              r_status;

  logic              w_loop;
  logic [MEM_AW-1:0] w_loop_addr;
  logic              w_issue;
  logic [MEM_AW-1:0] w_issue_addr;
  logic [CntW-1:0]   w_cnt_inc;
  logic              w_last;
  logic              w_toggle;

`ifdef MSU_FEEDER_LOOP_EN
  logic [MEM_AW-1:0] r_loop;
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_loop <= '0;
    end else if (r_state == StIdle && start && !stop) begin
      r_loop <= loop_point;
    end
  end
  assign w_loop      = loop_en && (r_loop != r_end);
  assign w_loop_addr = r_loop;
`else
  logic w_unused;
  assign w_unused    = loop_en ^ (^loop_point);
  assign w_loop      = 1'b0;
  assign w_loop_addr = r_end;
`endif

  // A read is issued from the current address, or from the loop point when sitting at track end.
  assign w_issue      = (r_addr != r_end) || w_loop;
  assign w_issue_addr = (r_addr != r_end) ? r_addr : w_loop_addr;
  assign w_cnt_inc    = r_cnt + CntW'(1);
  assign w_last       = (w_cnt_inc == (r_prime ? FullCnt : HalfCnt));
  assign w_toggle     = dac_status ^ r_status;

  always_comb begin
    w_state_d     = r_state;
    w_req_d       = r_req;
    w_addr_d      = r_addr;
    w_end_d       = r_end;
    w_data_d      = r_data;
    w_pend_d      = r_pend;
    w_we_n_d      = 1'b1;
    w_pgm_addr_d  = r_pgm_addr;
    w_pgm_data_d  = r_pgm_data;
    w_wptr_d      = r_wptr;
    w_cnt_d       = r_cnt;
    w_prime_d     = r_prime;
    w_abort_d     = r_abort;
    w_play_d      = r_play;
    w_dac_reset_d = 1'b0;
    w_playing_d   = r_playing;
    w_underrun_d  = r_underrun;

    if (r_abort) begin
      // Stopped with a read outstanding: finish the handshake, drop the byte.
      if (bus.mem_rd_ack) begin
        w_req_d     = 1'b0;
        w_abort_d   = 1'b0;
        w_playing_d = 1'b0;
        w_state_d   = StIdle;
      end
    end else if (stop && r_state != StIdle) begin
      w_play_d = 1'b0;
      w_pend_d = 1'b0;
      if (r_req && !bus.mem_rd_ack) begin
        w_abort_d = 1'b1;
      end else begin
        w_req_d     = 1'b0;
        w_playing_d = 1'b0;
        w_state_d   = StIdle;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start && !stop) begin
            w_addr_d      = track_start;
            w_end_d       = track_end;
            w_wptr_d      = '0;
            w_cnt_d       = '0;
            w_prime_d     = 1'b1;
            w_dac_reset_d = 1'b1;
            w_underrun_d  = 1'b0;
            w_playing_d   = 1'b1;
            w_req_d       = (track_start < track_end);
            w_state_d     = StPrime;
          end
        end
        StPrime, StFill: begin
          if (r_state == StFill && w_toggle) w_underrun_d = 1'b1;
          if (r_req && bus.mem_rd_ack) begin
            w_req_d  = 1'b0;
            w_data_d = bus.mem_data;
            w_addr_d = r_addr + MEM_AW'(1);
            w_pend_d = 1'b1;
          end
          if (r_pend) begin
            w_we_n_d     = 1'b0;
            w_pgm_addr_d = r_wptr;
            w_pgm_data_d = r_data;
            w_wptr_d     = r_wptr + BUF_AW'(1);
            w_cnt_d      = w_cnt_inc;
            w_pend_d     = 1'b0;
            if (w_last) begin
              w_cnt_d   = '0;
              w_state_d = StWait;
              if (r_prime) begin
                w_play_d  = 1'b1;
                w_prime_d = 1'b0;
              end
            end else if (w_issue) begin
              w_req_d  = 1'b1;
              w_addr_d = w_issue_addr;
            end
          end else if (!r_req) begin
            // Nothing outstanding and no read issued: the track has ended.
            w_state_d = StPad;
          end
        end
        StWait: begin
          if (w_toggle) begin
            w_state_d = StFill;
            w_wptr_d  = {r_status, {(BUF_AW - 1){1'b0}}};
            w_cnt_d   = '0;
            if (w_issue) begin
              w_req_d  = 1'b1;
              w_addr_d = w_issue_addr;
            end
          end
        end
        StPad: begin
          w_we_n_d     = 1'b0;
          w_pgm_addr_d = r_wptr;
          w_pgm_data_d = 8'h00;
          w_wptr_d     = r_wptr + BUF_AW'(1);
          w_cnt_d      = w_cnt_inc;
          if (w_last) begin
            w_cnt_d   = '0;
            w_state_d = StDrain1;
            if (r_prime) begin
              w_play_d  = 1'b1;
              w_prime_d = 1'b0;
            end
          end
        end
        StDrain1: begin
          if (w_toggle) w_state_d = StDrain2;
        end
        StDrain2: begin
          if (w_toggle) begin
            w_play_d    = 1'b0;
            w_playing_d = 1'b0;
            w_state_d   = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_end       <= '0;
      r_data      <= '0;
      r_pend      <= 1'b0;
      r_we_n      <= 1'b1;
      r_pgm_addr  <= '0;
      r_pgm_data  <= '0;
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_prime     <= 1'b0;
      r_abort     <= 1'b0;
      r_play      <= 1'b0;
      r_dac_reset <= 1'b0;
      r_playing   <= 1'b0;
      r_underrun  <= 1'b0;
      r_status    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_req       <= w_req_d;
      r_addr      <= w_addr_d;
      r_end       <= w_end_d;
      r_data      <= w_data_d;
      r_pend      <= w_pend_d;
      r_we_n      <= w_we_n_d;
      r_pgm_addr  <= w_pgm_addr_d;
      r_pgm_data  <= w_pgm_data_d;
      r_wptr      <= w_wptr_d;
      r_cnt       <= w_cnt_d;
      r_prime     <= w_prime_d;
      r_abort     <= w_abort_d;
      r_play      <= w_play_d;
      r_dac_reset <= w_dac_reset_d;
      r_playing   <= w_playing_d;
      r_underrun  <= w_underrun_d;
      r_status    <= dac_status;
    end
  end

  assign bus.mem_rd_req  = r_req;
  assign bus.mem_addr    = r_addr;
  assign bus.pgm_we_n    = r_we_n;
  assign bus.pgm_address = r_pgm_addr;
  assign bus.pgm_data    = r_pgm_data;
  assign dac_play        = r_play;
  assign dac_reset       = r_dac_reset;
  assign playing         = r_playing;
  assign underrun        = r_underrun;
endmodule

// File: tb/tb_msu_audio_feeder.sv
// Directed bench for msu_audio_feeder: prime, refill, underrun, track end, stop, reset, empty track.
module tb_msu_audio_feeder;
  localparam int unsigned BUF_AW = 11;
  localparam int unsigned MEM_AW = 24;

  logic              clkin = 1'b0;
  logic              reset;
  logic              start, stop, loop_en, dac_status;
  logic [MEM_AW-1:0] track_start, track_end, loop_point;
  logic              dac_play, dac_reset, playing, underrun;

  int n_checks;
  int n_errors;
  int lat;
  int wait_cnt;
  int n_dac_reset;
  logic [BUF_AW-1:0] wq_addr[$];
  logic [7:0]        wq_data[$];

  msu_audio_feeder_if #(.BUF_AW(BUF_AW), .MEM_AW(MEM_AW)) bus ();

  msu_audio_feeder #(.BUF_AW(BUF_AW), .MEM_AW(MEM_AW)) dut (
    .clkin       (clkin),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .track_start (track_start),
    .track_end   (track_end),
    .loop_point  (loop_point),
    .dac_status  (dac_status),
    .bus         (bus),
    .dac_play    (dac_play),
    .dac_reset   (dac_reset),
    .playing     (playing),
    .underrun    (underrun)
  );

  always #5 clkin = ~clkin;

  // Sample memory contents; never zero so pad bytes are distinguishable.
  function automatic logic [7:0] mem_byte(input logic [MEM_AW-1:0] a);
    return {1'b1, a[6:0] ^ a[13:7]};
  endfunction

  always @(posedge clkin or posedge reset) begin
    if (reset) wait_cnt <= 0;
    else if (!bus.mem_rd_req || bus.mem_rd_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end
  assign bus.mem_rd_ack = bus.mem_rd_req && (wait_cnt >= lat);
  assign bus.mem_data   = mem_byte(bus.mem_addr);

  always @(negedge clkin) begin
    if (!reset && !bus.pgm_we_n) begin
      wq_addr.push_back(bus.pgm_address);
      wq_data.push_back(bus.pgm_data);
    end
    if (!reset && dac_reset) n_dac_reset <= n_dac_reset + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  function automatic logic cond(input int sel, input int arg);
    case (sel)
      0:       return dac_play == 1'b1;
      1:       return playing == 1'b0;
      default: return wq_addr.size() >= arg;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int sel, input int arg, input int budget);
    int n = 0;
    while (!cond(sel, arg) && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_reached"}, 32'(cond(sel, arg)), 1);
  endtask

  // Expected stream: len1 bytes from src, then either zeros or bytes from src2.
  task automatic check_writes(input string tag, input int n_exp, input int base, input int src,
                              input int len1, input int src2, input logic zero2);
    int bad_a = 0;
    int bad_d = 0;
    check({tag, "_count"}, wq_addr.size(), n_exp);
    for (int n = 0; n < wq_addr.size(); n++) begin
      logic [7:0]        e;
      logic [BUF_AW-1:0] ea;
      ea = BUF_AW'(base + n);
      if (n < len1) e = mem_byte(MEM_AW'(src + n));
      else if (zero2) e = 8'h00;
      else e = mem_byte(MEM_AW'(src2 + n - len1));
      if (wq_addr[n] != ea) bad_a++;
      if (wq_data[n] != e) bad_d++;
    end
    check({tag, "_addr"}, bad_a, 0);
    check({tag, "_data"}, bad_d, 0);
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"},      32'(bus.mem_rd_req),  0);
    check({tag, "_maddr"},    32'(bus.mem_addr),    0);
    check({tag, "_we_n"},     32'(bus.pgm_we_n),    1);
    check({tag, "_paddr"},    32'(bus.pgm_address), 0);
    check({tag, "_pdata"},    32'(bus.pgm_data),    0);
    check({tag, "_play"},     32'(dac_play),        0);
    check({tag, "_dreset"},   32'(dac_reset),       0);
    check({tag, "_playing"},  32'(playing),         0);
    check({tag, "_underrun"}, 32'(underrun),        0);
  endtask

  task automatic start_track(input int s, input int e, input int lp);
    track_start = MEM_AW'(s);
    track_end   = MEM_AW'(e);
    loop_point  = MEM_AW'(lp);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic end_test(input string tag, input logic lp, input logic expect_loop);
    loop_en = lp;
    dac_status = 1'b0;
    tick(2);
    start_track('h100, 'hA00, 'h200);
    check({tag, "_ur_clr"}, 32'(underrun), 0);
    wait_for({tag, "_prime"}, 0, 0, 6000);
    tick(2);
    check_writes({tag, "_prime"}, 2048, 0, 'h100, 2048, 0, 1'b0);
    dac_status = 1'b1;
    wait_for({tag, "_fill"}, 2, 1024, 3000);
    tick(2);
    if (expect_loop) begin
      check_writes({tag, "_fill"}, 1024, 0, 'h900, 256, 'h200, 1'b0);
    end else begin
      check_writes({tag, "_fill"}, 1024, 0, 'h900, 256, 0, 1'b1);
      dac_status = 1'b0;
      tick(3);
      check({tag, "_drain1_play"}, 32'(dac_play), 1);
      check({tag, "_drain1_playing"}, 32'(playing), 1);
      dac_status = 1'b1;
      tick(3);
      check({tag, "_drain2_play"}, 32'(dac_play), 0);
      check({tag, "_drain2_playing"}, 32'(playing), 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_dac_reset = 0;
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    dac_status = 1'b0;
    track_start = '0;
    track_end = '0;
    loop_point = '0;
    lat = 0;
    tick(3);
    check_reset_vals("rst");
    reset = 1'b0;
    tick(2);

    // Prime from 0x100 with zero-latency memory, then two refills.
    start_track('h100, 'h10000, 0);
    check("start_dreset", 32'(dac_reset), 1);
    check("start_playing", 32'(playing), 1);
    check("start_maddr", 32'(bus.mem_addr), 'h100);
    wait_for("prime", 0, 0, 6000);
    tick(2);
    check_writes("prime", 2048, 0, 'h100, 2048, 0, 1'b0);
    check("prime_dreset_cnt", n_dac_reset, 1);
    check("prime_req_idle", 32'(bus.mem_rd_req), 0);
    dac_status = 1'b1;
    wait_for("fill_lo", 2, 1024, 3000);
    tick(2);
    check_writes("fill_lo", 1024, 0, 'h900, 1024, 0, 1'b0);
    dac_status = 1'b0;
    wait_for("fill_hi", 2, 1024, 3000);
    tick(2);
    check_writes("fill_hi", 1024, 'h400, 'hD00, 1024, 0, 1'b0);
    check("fill_underrun", 32'(underrun), 0);

    // Slow memory: DAC overtakes the fill.
    lat = 600;
    dac_status = 1'b1;
    tick(300);
    check("ur_pre", 32'(underrun), 0);
    dac_status = 1'b0;
    tick(2);
    check("ur_set", 32'(underrun), 1);
    lat = 0;
    wait_for("fill_ur", 2, 1024, 3000);
    tick(2);
    check_writes("fill_ur", 1024, 0, 'h1100, 1024, 0, 1'b0);
    check("ur_sticky", 32'(underrun), 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(1);
    check("stop_wait_playing", 32'(playing), 0);

    // Track end, with and without looping.
`ifdef MSU_FEEDER_LOOP_EN
    end_test("loop", 1'b1, 1'b1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(2);
    end_test("noloop", 1'b0, 1'b0);
`else
    end_test("noloop", 1'b1, 1'b0);
`endif

    // Stop with a read outstanding.
    loop_en = 1'b0;
    dac_status = 1'b0;
    tick(2);
    start_track('h100, 'h10000, 0);
    wait_for("stop_prime", 0, 0, 6000);
    tick(2);
    wq_addr.delete();
    wq_data.delete();
    lat = 5;
    dac_status = 1'b1;
    tick(2);
    check("stop_pre_req", 32'(bus.mem_rd_req), 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_play", 32'(dac_play), 0);
    check("stop_req_held", 32'(bus.mem_rd_req), 1);
    check("stop_playing_held", 32'(playing), 1);
    tick(8);
    check("stop_req_done", 32'(bus.mem_rd_req), 0);
    check("stop_playing", 32'(playing), 0);
    check("stop_no_writes", wq_addr.size(), 0);

    // Asynchronous reset in the middle of a fill.
    lat = 0;
    dac_status = 1'b0;
    tick(2);
    start_track('h100, 'h10000, 0);
    wait_for("rst_prime", 0, 0, 6000);
    tick(2);
    wq_addr.delete();
    wq_data.delete();
    dac_status = 1'b1;
    tick(20);
    check("rst_fill_active", 32'(playing), 1);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_fill");
    tick(2);
    reset = 1'b0;
    wq_addr.delete();
    wq_data.delete();

    // Empty track zeroes the whole buffer.
    dac_status = 1'b0;
    tick(2);
    start_track('h1000, 'h1000, 0);
    wait_for("empty", 0, 0, 6000);
    tick(2);
    check_writes("empty", 2048, 0, 0, 0, 0, 1'b1);
    dac_status = 1'b1;
    tick(3);
    check("empty_drain1_play", 32'(dac_play), 1);
    dac_status = 1'b0;
    tick(3);
    check("empty_drain2_play", 32'(dac_play), 0);
    check("empty_drain2_playing", 32'(playing), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/msu_audio_feeder.md
Name: msu_audio_feeder

Overview:
- Streams 8-bit audio bytes from external sample memory into the 2 KiB DAC ring buffer (write side, 11-bit byte address, active-low write strobe).
- Sits directly upstream of the audio DAC. Primes both buffer halves, then refills whichever half the DAC has just finished.
- Drives the DAC's play/reset controls and handles track end, looping, stop and underrun.

Parameters:
BUF_AW, 11, buffer byte-address width; half size = 2^(BUF_AW-1) = 1024 bytes
MEM_AW, 24, sample-memory byte-address width

Ports:
clkin  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: begin track at track_start
stop  in  1  one-cycle pulse: abort playback
loop_en  in  1  loop to loop_point at track end
track_start  in  MEM_AW  first byte address, sampled on start
track_end  in  MEM_AW  exclusive end address, sampled on start
loop_point  in  MEM_AW  loop restart address, sampled on start
dac_status  in  1  DAC half currently playing (0 = lower, 1 = upper)
mem_rd_req  out  1  read request
mem_addr  out  MEM_AW  read address, stable while mem_rd_req = 1
mem_rd_ack  in  1  one-cycle pulse, mem_data valid in the same cycle
mem_data  in  8  read data
pgm_we_n  out  1  buffer write strobe, active low
pgm_address  out  BUF_AW  buffer byte address
pgm_data  out  8  buffer byte
dac_play  out  1  DAC play enable
dac_reset  out  1  one-cycle pulse; DAC reloads address 0
playing  out  1  status: track active
underrun  out  1  sticky; cleared on start

Behaviour:
- Reset values: mem_rd_req=0, mem_addr=0, pgm_we_n=1, pgm_address=0, pgm_data=0, dac_play=0, dac_reset=0, playing=0, underrun=0, state=IDLE.
- States are IDLE, PRIME, WAIT, FILL, PAD, DRAIN1, DRAIN2.
- IDLE: on start
  - Latch the three addresses; set mem_addr=track_start, write pointer=0.
  - Pulse dac_reset for 1 cycle; clear underrun; playing=1; go to PRIME.
- Handshake (PRIME/FILL):
  - mem_rd_req rises on a clock edge and holds with a constant mem_addr until the cycle mem_rd_ack=1 is sampled.
  - On that edge: mem_rd_req drops, mem_data is registered, mem_addr increments.
  - Next cycle: pgm_we_n=0 for exactly 1 cycle with pgm_address=write pointer and pgm_data=registered byte; mem_rd_req re-asserts on that same edge if bytes remain.
  - The write pointer increments after each write and wraps at 2^BUF_AW.
  - Throughput: one byte per 2 cycles at zero memory latency.
- Track end: checked before issuing each read; triggers when mem_addr == track_end.
  - If loop_en=1 and loop_point != track_end: mem_addr <= loop_point and the fill continues without a gap cycle.
  - Otherwise go to PAD.
- PRIME: fills all 2048 bytes (lower half first). Then dac_play=1 and go to WAIT.
- WAIT: register dac_status. On a toggle, go to FILL targeting the half just left (old dac_status value); the write pointer is set to that half's base.
- FILL: writes 1024 bytes, then returns to WAIT.
  - If dac_status toggles during FILL, set underrun=1 and finish the fill.
- PAD: writes 0x00 each cycle (no memory reads) until the current half is complete, then go to DRAIN1.
  - If PAD completes during PRIME, the untouched half is also zero-filled; dac_play=1 is asserted, then go to DRAIN1.
- DRAIN1: wait for a dac_status toggle (playback entered the last written half), then go to DRAIN2.
- DRAIN2: on the next toggle: dac_play=0, playing=0, go to IDLE.
- Empty track (track_start >= track_end at start): PRIME immediately enters PAD; the whole buffer is zeroed.
- stop (any non-IDLE state):
  - dac_play=0 on the next edge.
  - If mem_rd_req=1, hold it until ack and discard the data; then playing=0 and go to IDLE.
  - No further buffer writes after the stop edge.
- start outside IDLE is ignored. start and stop in the same cycle: stop wins.
- Asynchronous reset mid-transfer forces the reset values immediately; the memory side must tolerate an abandoned request.

Optional Feature:
- Macro: MSU_FEEDER_LOOP_EN.
- Defined: loop_en/loop_point behave as above.
- Undefined: loop_en treated as 0, loop_point unused and no loop register is built; track end always goes to PAD.

Test Plan:
- Prime, zero-latency memory, track_start=0x000100, track_end=0x010000: 2048 pgm_we_n pulses at addresses 0..2047 with data = mem[0x100+n]; then dac_play=1; dac_reset pulsed once after start.
- dac_status 0→1 → 1024 writes at pgm_address 0x000..0x3FF from mem 0x000900 onward; 1→0 → writes at 0x400..0x7FF; underrun=0.
- Memory ack latency 600 cycles, dac_status toggles mid-FILL → underrun=1 (sticky), fill completes, next start clears it.
- track_end=0x000A00, loop_en=1, loop_point=0x000200 → byte after 0x0009FF is read from 0x000200, no zero bytes written. Same with loop_en=0 → remainder of half written 0x00, two dac_status toggles later dac_play=0, playing=0.
- stop while mem_rd_req=1 and ack pending 5 cycles → dac_play=0 next cycle, mem_rd_req held until ack, no pgm_we_n pulse, IDLE after ack.
- Assert reset during FILL → all outputs at reset values in the same cycle. Empty track (start=end=0x1000) → 2048 zero writes, dac_play=1, stops after two toggles.
